// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory load/store front end.
// Size encodings, FSM states and access checks reused by decode.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic access_err(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] words
    );
        logic out_of_range;
        out_of_range = {2'b00, addr[31:2]} >= words;
        return misaligned(size, addr[1:0]) | out_of_range;
    endfunction

endpackage

// File: rtl/mau_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores.
// Little-endian: byte offset k lives in bits [8k+7:8k].
module mau_align
    import mau_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;

    always_comb begin
        shifted   = word >> {offset, 3'b000};
        rdata     = word;
        lane_mask = '1;
        case (size)
            SZ_BYTE: begin
                rdata     = {{24{~uns & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00ff << {offset, 3'b000};
            end
            SZ_HALF: begin
                rdata     = {{16{~uns & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_ffff << {offset[1], 4'b0000};
            end
            default: ;
        endcase
        merged = (word & ~lane_mask)
               | ((wdata << {offset, 3'b000}) & lane_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks, extends loads, RMW for sub-word
// stores; the memory only sees whole-word exclusive rd/wr strobes.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        accept;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept  = req_valid & req_ready;
    assign req_err = access_err(req_size, req_addr, 32'(MEM_WORDS));

    mau_align u_align (
        .offset (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .rdata  (ld_data),
        .merged (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)               state_nxt = ST_RESP;
                    else if (!req_we)          state_nxt = ST_LOAD;
                    else if (req_size == SZ_WORD) state_nxt = ST_WRITE;
                    else                       state_nxt = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_rd    = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_rd    = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr    = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                off_q      <= req_addr[1:0];
                wdata_q    <= req_wdata;
                err_q      <= req_err;
                mem_addr   <= {req_addr[31:2], 2'b00};
                resp_rdata <= '0;
                if (req_we) mem_wdata <= req_wdata;
            end
            if (state == ST_LOAD)   resp_rdata <= ld_data;
            // untouched bytes come from the word just read
            if (state == ST_RMW_RD) mem_wdata  <= merged;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word-array memory model.
// Stimulus pushes expected responses/strobes; monitors pop and compare.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } strb_t;

    resp_t resp_q[$];
    strb_t strb_q[$];
    resp_t rr;
    strb_t ss;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc;

    logic [31:0] mem [0:1023];

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_wr) mem[mem_addr[11:2]] = mem_wdata;

    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: got resp at cyc %0d expected none", cyc);
            end else begin
                rr = resp_q.pop_front();
                chk("resp_err", {31'b0, resp_err}, {31'b0, rr.err});
                chk("resp_rdata", resp_rdata, rr.rdata);
                chk("resp_cycle", 32'(cyc), 32'(rr.cyc));
            end
        end
    end

    // Memory strobe monitor
    always @(negedge clk) begin
        if (mem_rd | mem_wr) begin
            if (mem_rd & mem_wr) begin
                n_vec++;
                n_err++;
                $display("FAIL strobe_excl: got rd=1 wr=1 expected one");
            end
            if (strb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got rd=%b wr=%b addr %h expected none",
                         mem_rd, mem_wr, mem_addr);
            end else begin
                ss = strb_q.pop_front();
                chk("strobe_kind", {31'b0, mem_wr}, {31'b0, ss.wr});
                chk("mem_addr", mem_addr, ss.addr);
                chk("strobe_cycle", 32'(cyc), 32'(ss.cyc));
                if (ss.wr) chk("mem_wdata", mem_wdata, ss.data);
            end
        end
    end

    task automatic exp_strb(input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int c);
        strb_q.push_back('{wr: wr, addr: a, data: d, cyc: c});
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic want_resp,
                         input logic e_err, input logic [31:0] e_rd,
                         input int lat, output int a_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        a_cyc        = cyc + 1;
        if (want_resp)
            resp_q.push_back('{err: e_err, rdata: e_rd, cyc: a_cyc + lat});
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = 32'hdead_beef;
        req_wdata    = 32'h5a5a_5a5a;
        req_unsigned = ~uns;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || strb_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() != 0 || strb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d resp %0d strobes outstanding expected 0",
                     resp_q.size(), strb_q.size());
            resp_q.delete();
            strb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h1;
        mem[2] = 32'h2;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // lw 0x8
        issue(1'b0, 2'b10, 1'b0, 32'h8, 0, 1'b1, 1'b0, 32'h2, 1, acc);
        exp_strb(1'b0, 32'h8, 0, acc);
        drain();
        // sb 0xAB at 0x5: RMW of word1
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00ab, 1'b1, 1'b0, 32'h0, 2, acc);
        exp_strb(1'b0, 32'h4, 0, acc);
        exp_strb(1'b1, 32'h4, 32'h0000_ab01, acc + 1);
        drain();
        issue(1'b0, 2'b00, 1'b0, 32'h5, 0, 1'b1, 1'b0, 32'hffff_ffab, 1, acc);
        exp_strb(1'b0, 32'h4, 0, acc);
        issue(1'b0, 2'b00, 1'b1, 32'h5, 0, 1'b1, 1'b0, 32'h0000_00ab, 1, acc);
        exp_strb(1'b0, 32'h4, 0, acc);
        drain();
        // sh 0x1234 at 0x6
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'hffff_1234, 1'b1, 1'b0, 32'h0, 2, acc);
        exp_strb(1'b0, 32'h4, 0, acc);
        exp_strb(1'b1, 32'h4, 32'h1234_ab01, acc + 1);
        drain();
        chk("word1_after_sh", mem[1], 32'h1234_ab01);
        issue(1'b0, 2'b01, 1'b0, 32'h6, 0, 1'b1, 1'b0, 32'h0000_1234, 1, acc);
        exp_strb(1'b0, 32'h4, 0, acc);
        drain();
        // sw and last in-range word
        issue(1'b1, 2'b10, 1'b0, 32'hc, 32'hcafe_f00d, 1'b1, 1'b0, 32'h0, 1, acc);
        exp_strb(1'b1, 32'hc, 32'hcafe_f00d, acc);
        issue(1'b0, 2'b10, 1'b0, 32'hffc, 0, 1'b1, 1'b0, 32'h0, 1, acc);
        exp_strb(1'b0, 32'hffc, 0, acc);
        drain();
        // error cases: no strobes, response one cycle after acceptance
        issue(1'b0, 2'b01, 1'b0, 32'h3, 0, 1'b1, 1'b1, 32'h0, 0, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h2, 0, 1'b1, 1'b1, 32'h0, 0, acc);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h0, 0, acc);
        issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 1'b1, 1'b1, 32'h0, 0, acc);
        drain();

        // reset during RMW_RD aborts the store
        issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00cd, 1'b0, 1'b0, 32'h0, 0, acc);
        exp_strb(1'b0, 32'h8, 0, acc);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("abort_mem_rd", {31'b0, mem_rd}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_word2", mem[2], 32'h2);
        drain();

        // back-to-back lw with req_valid held high
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h8;
        acc          = cyc + 1;
        resp_q.push_back('{err: 1'b0, rdata: 32'h2, cyc: acc + 1});
        resp_q.push_back('{err: 1'b0, rdata: 32'h1234_ab01, cyc: acc + 4});
        exp_strb(1'b0, 32'h8, 0, acc);
        exp_strb(1'b0, 32'h4, 0, acc + 3);
        @(posedge clk);
        #1;
        req_addr = 32'h4;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();
        chk("final_word2", mem[2], 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
